// File: rtl/fp_recip_pkg.sv
// Shared definitions for the Newton-Raphson mantissa reciprocal sequencer.
// Holds the FSM state type, mantissa/LUT geometry, the fixed-point constants
// used by the refinement step, and the seed generator for the reciprocal ROM.
package fp_recip_pkg;

    localparam int MANT_W      = 24;
    localparam int LUT_BITS    = 8;
    localparam int SEED_IDX_HI = 22;
    localparam int SEED_IDX_LO = 15;

    // 1.0 in Q1.23
    localparam logic [MANT_W-1:0] ONE_Q1_23  = 24'h800000;
    // 4.0 in Q2.46, one bit wider so 4 - d*x never wraps
    localparam logic [2*MANT_W:0] FOUR_Q2_46 = 49'h1_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_MUL1,
        ST_MUL2,
        ST_DONE
    } state_e;

    // Seed for one ROM entry: 2/d evaluated at the midpoint of the mantissa
    // interval selected by the index, in Q1.23. Midpoint sampling halves the
    // worst-case seed error compared to using the interval start.
    function automatic logic [MANT_W-1:0] seed_value(input int unsigned idx);
        logic [63:0] d_mid;
        logic [63:0] q;
        d_mid = 64'(ONE_Q1_23) + (64'(idx) << SEED_IDX_LO) + (64'h1 << (SEED_IDX_LO - 1));
        q     = (64'h1 << 47) / d_mid;
        return MANT_W'(q);
    endfunction

endpackage

// File: rtl/mantissa_reciprocal_24bit_LUT.sv
// Registered reciprocal seed ROM.
// Ports:
//   clk - clock, rising edge
//   in  - LUT_BITS-wide index (mantissa bits just below the hidden bit)
//   out - 2/d seed in Q1.23, valid one cycle after the index is presented
module mantissa_reciprocal_24bit_LUT
    import fp_recip_pkg::*;
(
    input  logic                clk,
    input  logic [LUT_BITS-1:0] in,
    output logic [MANT_W-1:0]   out
);

    localparam int DEPTH = 1 << LUT_BITS;

    logic [MANT_W-1:0] rom [DEPTH];
    logic [MANT_W-1:0] out_d;
    logic [MANT_W-1:0] out_q;

    // Contents are constant-folded; no divider is built.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = seed_value(i);
    end

    assign out_d = rom[in];

    always_ff @(posedge clk) begin
        out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: rtl/recip_nr_sequencer.sv
// Newton-Raphson reciprocal sequencer for 24-bit normalized mantissas.
// Produces 2/d in Q1.23 from a LUT seed refined ITERATIONS times on a shared
// external 24x24 multiplier (req/ack, two transactions per refinement step).
// Ports:
//   clk, rst            - clock; asynchronous active-low reset
//   valid_data_in, in   - request and divisor mantissa d (Q1.23, in[23]=1)
//   in_ready            - high only while idle
//   out, out_exact      - result and "d was exactly 1.0" flag, held until next result
//   valid_data_out      - one-cycle result strobe
//   mul_req/a/b         - multiplier request and operands (stable while mul_req)
//   mul_ack, mul_p      - multiplier completion pulse and 48-bit product
//
// state | meaning
// IDLE  | waiting for a request; LUT address follows the input
// SEED  | LUT read cycle; seed loaded into x
// MUL1  | t = 4 - d*x
// MUL2  | x = x*t/2
// DONE  | publish x and pulse valid_data_out
module recip_nr_sequencer
    import fp_recip_pkg::*;
#(
    parameter int ITERATIONS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_data_in,
    input  logic [MANT_W-1:0]   in,
    output logic                in_ready,
    output logic [MANT_W-1:0]   out,
    output logic                out_exact,
    output logic                valid_data_out,
    output logic                mul_req,
    output logic [MANT_W-1:0]   mul_a,
    output logic [MANT_W-1:0]   mul_b,
    input  logic                mul_ack,
    input  logic [2*MANT_W-1:0] mul_p
);

    localparam logic [1:0] ITER_LAST = 2'(ITERATIONS);

    state_e            state_q, state_d;
    logic [MANT_W-1:0] d_q, d_d;
    logic [MANT_W-1:0] x_q, x_d;
    logic [MANT_W-1:0] t_q, t_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              exact_q, exact_d;
    logic              mul_req_q, mul_req_d;
    logic [MANT_W-1:0] mul_a_q, mul_a_d;
    logic [MANT_W-1:0] mul_b_q, mul_b_d;
    logic [MANT_W-1:0] out_q, out_d;
    logic              out_exact_q, out_exact_d;
    logic              valid_q, valid_d;
    logic              in_ready_q, in_ready_d;

    logic [MANT_W-1:0] lut_data;
    logic [2*MANT_W:0] t49;
    logic [MANT_W-1:0] x_nr;
    logic [1:0]        cnt_inc;
    logic              unused_t49;

    mantissa_reciprocal_24bit_LUT u_lut (
        .clk (clk),
        .in  (in[SEED_IDX_HI:SEED_IDX_LO]),
        .out (lut_data)
    );

    // t = 4 - d*x, truncated to Q2.22
    assign t49        = FOUR_Q2_46 - {1'b0, mul_p};
    assign unused_t49 = ^{t49[2*MANT_W], t49[MANT_W-1:0]};

    // x*t is Q3.45; halving and taking Q1.23 selects [46:23]. A set bit 47
    // means the refined value reached 2.0, which Q1.23 cannot hold.
    assign x_nr    = mul_p[2*MANT_W-1] ? '1 : mul_p[2*MANT_W-2:MANT_W-1];
    assign cnt_inc = cnt_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        x_d         = x_q;
        t_d         = t_q;
        cnt_d       = cnt_q;
        exact_d     = exact_q;
        mul_req_d   = mul_req_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_d       = out_q;
        out_exact_d = out_exact_q;
        valid_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_data_in) begin
                    d_d   = in;
                    cnt_d = '0;
                    if (in == ONE_Q1_23) begin
                        x_d     = ONE_Q1_23;
                        exact_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        exact_d = 1'b0;
                        state_d = ST_SEED;
                    end
                end
            end
            ST_SEED: begin
                x_d     = lut_data;
                cnt_d   = '0;
                state_d = ST_MUL1;
            end
            // Each MUL state raises its request one cycle after entry, which
            // leaves a request-free cycle between back-to-back transactions.
            ST_MUL1: begin
                if (!mul_req_q) begin
                    mul_req_d = 1'b1;
                    mul_a_d   = d_q;
                    mul_b_d   = x_q;
                end else if (mul_ack) begin
                    t_d       = t49[2*MANT_W-1:MANT_W];
                    mul_req_d = 1'b0;
                    state_d   = ST_MUL2;
                end
            end
            ST_MUL2: begin
                if (!mul_req_q) begin
                    mul_req_d = 1'b1;
                    mul_a_d   = x_q;
                    mul_b_d   = t_q;
                end else if (mul_ack) begin
                    x_d       = x_nr;
                    mul_req_d = 1'b0;
                    cnt_d     = cnt_inc;
                    state_d   = (cnt_inc == ITER_LAST) ? ST_DONE : ST_MUL1;
                end
            end
            ST_DONE: begin
                out_d       = x_q;
                out_exact_d = exact_q;
                valid_d     = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            d_q         <= '0;
            x_q         <= '0;
            t_q         <= '0;
            cnt_q       <= '0;
            exact_q     <= 1'b0;
            mul_req_q   <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_q       <= '0;
            out_exact_q <= 1'b0;
            valid_q     <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            x_q         <= x_d;
            t_q         <= t_d;
            cnt_q       <= cnt_d;
            exact_q     <= exact_d;
            mul_req_q   <= mul_req_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_q       <= out_d;
            out_exact_q <= out_exact_d;
            valid_q     <= valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out            = out_q;
    assign out_exact      = out_exact_q;
    assign valid_data_out = valid_q;
    assign mul_req        = mul_req_q;
    assign mul_a          = mul_a_q;
    assign mul_b          = mul_b_q;

endmodule

// File: doc/recip_nr_sequencer.md
Name: recip_nr_sequencer

Overview:
Sequences a Newton-Raphson refinement of the 24-bit mantissa reciprocal. The block takes a normalized mantissa, fetches an 8-bit-indexed seed from the registered reciprocal LUT, then runs ITERATIONS refinement steps on a shared external 24x24 multiplier through a req/ack handshake. It sits in front of the FP divide path. Its result feeds the final mantissa multiply; exponent handling stays outside this block.

Parameters:
ITERATIONS, 2, NR refinement steps (1..3); each step uses 2 multiplier transactions
MANT_W, 24, mantissa width including hidden bit (fixed at 24)
LUT_BITS, 8, seed index width; index = in[22:15]

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
valid_data_in  in  1  request; accepted when high in a cycle with in_ready=1
in  in  24  divisor mantissa d, Q1.23, in[23] must be 1
in_ready  out  1  high only in IDLE
out  out  24  2/d in Q1.23 (value in (1,2]; d=1.0 yields 24'h800000 as a flagged exact case)
out_exact  out  1  high with valid_data_out when d==24'h800000
valid_data_out  out  1  one-cycle pulse; out/out_exact held until next pulse
mul_req  out  1  multiplier request
mul_a  out  24  operand A, stable while mul_req=1
mul_b  out  24  operand B, stable while mul_req=1
mul_ack  in  1  one-cycle pulse; mul_p valid in same cycle
mul_p  in  48  unsigned product A*B

Behaviour:
- Reset (rst=0, async): state=IDLE, in_ready=1 after release, mul_req=0, mul_a=mul_b=0, out=0, out_exact=0, valid_data_out=0, iteration counter=0. Reset mid-transaction drops mul_req immediately. Any later mul_ack is ignored in IDLE.
- FSM states: IDLE, SEED, MUL1, MUL2, DONE.
- IDLE: on valid_data_in, latch d. If d==24'h800000, go to DONE with x=24'h800000 and out_exact=1 (no multiplier use). Otherwise drive LUT address in[22:15] and go to SEED.
- SEED, 1 cycle, covering LUT read latency: x <= LUT data; cnt <= 0; go to MUL1.
- MUL1: mul_req=1, mul_a=d, mul_b=x. On mul_ack: t49 = 2^48 - mul_p (49-bit), t = t49[47:24] (Q2.22, value about 2). Drop mul_req next cycle, go to MUL2.
- MUL2: mul_req=1, mul_a=x, mul_b=t. On mul_ack: x <= mul_p[47] ? 24'hFFFFFF : mul_p[46:23]. Then cnt+1; if cnt+1==ITERATIONS go to DONE, else go to MUL1.
- mul_req deasserts in the cycle after mul_ack (registered). No new req is raised in that same cycle, so there is at least one idle cycle between transactions.
- DONE, 1 cycle: out <= x, valid_data_out=1, go to IDLE.
- in_ready=0 in every state except IDLE. valid_data_in while busy is ignored, not queued.
- Latency with a zero-wait multiplier (ack in the cycle after req rises): exact case is 2 cycles from accept to valid_data_out. General case is 2 + 4*ITERATIONS + 1 cycles (11 at default). Each extra wait cycle on ack adds 1.
- Accuracy: result within ±2 LSB of floor(2^24/d_real) for ITERATIONS=2.
- mul_ack while mul_req=0 is ignored in all states.

Decomposition:
- Package fp_recip_pkg holds: the state enum; MANT_W; the constant 24'h800000 (ONE_Q1_23); the constant 49'h1_0000_0000_0000 (FOUR_Q2_46); the seed index slice bounds.
- Single sub-module: the existing mantissa_reciprocal_24bit_LUT, instantiated inside, clk shared, in=lut address.
- Multiplier remains external so it can be arbitrated with the divide path.

Test Plan:
- d=24'hC00000 (1.5), 1-cycle ack -> valid_data_out 11 cycles after accept, out=24'hAAAAAA ±2, out_exact=0, exactly 4 mul_req pulses.
- d=24'h800000 -> valid_data_out 2 cycles after accept, out=24'h800000, out_exact=1, mul_req never rises.
- d=24'hFFFFFF -> out=24'h800001 ±2. Random ack delay 0-7 cycles -> same result; mul_a/mul_b stable while mul_req=1.
- valid_data_in pulsed every cycle during an operation -> in_ready=0, only the first d processed, one valid_data_out.
- rst low during MUL2 with mul_ack arriving 1 cycle later -> mul_req=0 same cycle, outputs reset, stale ack ignored. Next request d=24'hC00000 completes correctly.
- Spurious mul_ack in IDLE or SEED -> no state change, no output pulse.
